round_combiner: RTL and testbench
=================================

Name: round_combiner

Overview:
Output-side counterpart to the round input register.
- Accepts one left/right 32-bit half pair per completed Feistel round and counts rounds.
- After the final round, applies the DES final swap to form a 64-bit result.
- Buffers results in a small FIFO and presents them downstream over a valid/ready handshake.
- Sits between the round datapath and the block output / host interface.

Parameters:
NUM_ROUNDS, 16, number of round strobes per block; legal range 2..64.
FIFO_DEPTH, 2, number of completed 64-bit blocks buffered; power of two, 2..8.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush of counter and FIFO.
left_block  input  32  round output left half (L_i).
right_block  input  32  round output right half (R_i).
round_valid  input  1  one round's halves are valid this cycle.
in_ready  output  1  block accepts round_valid this cycle.
data_out  output  64  FIFO head block.
data_valid  output  1  FIFO non-empty.
out_ready  input  1  downstream accepts data_out.
round_count  output  6  rounds accepted in the current block, 0..NUM_ROUNDS-1.
block_done  output  1  one-cycle pulse, registered, in the cycle after a block is pushed.

Behaviour:
- Reset (n_rst low, asynchronous): round_count=0, FIFO empty, data_valid=0, data_out=64'd0, block_done=0. in_ready=1 once n_rst deasserts.
- clear is synchronous and has the highest priority:
  - Next cycle: round_count=0, FIFO empty, block_done=0.
  - Any round_valid or pop in the same cycle is discarded.
- Accept rule: a round is accepted when round_valid && in_ready.
  - in_ready = !(round_count==NUM_ROUNDS-1 && fifo_full).
  - in_ready is combinational from registered state only; it does not depend on out_ready (no full-FIFO pass-through).
- On an accepted round with round_count < NUM_ROUNDS-1: round_count increments. Halves are not stored; intermediate rounds carry only the count.
- On an accepted round with round_count == NUM_ROUNDS-1:
  - Push {right_block, left_block} (final swap R_n||L_n) at the write pointer.
  - round_count wraps to 0.
  - block_done=1 in the next cycle.
- Pop: occurs when data_valid && out_ready. The read pointer advances and the next entry appears on data_out the following cycle.
- Simultaneous push and pop:
  - Both are performed and occupancy is unchanged.
  - When full, a push is impossible because in_ready is low.
  - When empty, the pop is invalid, so only the push occurs; data_valid rises in the next cycle.
- FIFO implementation: registered storage. Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. A separate occupancy counter 0..FIFO_DEPTH gives full/empty.
- data_out when empty: holds the last head value. It is not required to be zero except after reset or clear, where it is 64'd0.
- Latency: final accepted round at edge N; data_valid=1 after edge N (if the FIFO was empty).
- round_valid while in_ready=0 is ignored, with no state change. The upstream datapath is required to hold its values until accepted.
- Reset asserted mid-block or mid-drain: all state is lost immediately; there is no partial output.

Optional Feature:
Macro ROUND_COMBINER_FP_EN.
- Defined: the pushed value is the DES final permutation (IP^-1) applied to {R_n, L_n}, as a fixed combinational bit remap before the FIFO write. Latency is unchanged.
- Undefined: the pushed value is raw {R_n, L_n}. No permutation logic is generated.

Test Plan:
- Reset then 16 round_valid pulses, with the final pulse carrying left=32'h01234567, right=32'h89ABCDEF -> data_valid=1 one cycle later, data_out=64'h89ABCDEF01234567, block_done single pulse, round_count back to 0. Build without FP_EN.
- out_ready=0, push 3 blocks with FIFO_DEPTH=2 -> after 2 blocks in_ready=0 at round_count=15. Assert out_ready for 1 cycle -> in_ready=1 next cycle; third block accepted; order is preserved on drain.
- FIFO holding 1 entry, final round accepted in the same cycle as a pop -> occupancy stays 1 and data_out shows the new block the next cycle.
- clear asserted at round_count=7 with the FIFO holding 1 entry and round_valid=1 -> next cycle round_count=0, data_valid=0, data_out=0, no block_done.
- n_rst pulsed low mid-cycle at round_count=10 -> outputs are immediately at reset values without waiting for clk; the next 16 rounds produce exactly one block.
- FP_EN defined, final halves L=32'h00000000, R=32'h00000001 -> data_out equals the IP^-1 of 64'h0000000100000000 per the DES table. Compare against a bench reference model.

Source files
------------

// File: rtl/round_combiner.sv
// ============================================================================
//  Module   : round_combiner
//  Purpose  : Counts Feistel rounds, applies the final L/R swap (optionally the
//             DES IP^-1 remap when ROUND_COMBINER_FP_EN is defined) and queues
//             completed 64-bit blocks for a valid/ready consumer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_combiner #(
    parameter int NUM_ROUNDS = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic [31:0] left_block,
    input  logic [31:0] right_block,
    input  logic        round_valid,
    output logic        in_ready,
    output logic [63:0] data_out,
    output logic        data_valid,
    input  logic        out_ready,
    output logic [5:0]  round_count,
    output logic        block_done
);

    localparam int          c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [5:0]  c_LAST  = 6'(NUM_ROUNDS - 1);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

    logic [5:0]         r_round_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [63:0]        r_hold;
    logic               r_block_done;
    logic [63:0]        r_mem [FIFO_DEPTH];

    logic               w_last;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [63:0]        w_swapped;
    logic [63:0]        w_push_data;

    assign w_last   = (r_round_count == c_LAST);
    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);

    // Stall only when the block-completing round has nowhere to go.
    assign in_ready = !(w_last && w_full);

    assign w_accept = round_valid && in_ready && !clear;
    assign w_push   = w_accept && w_last;
    assign w_pop    = !w_empty && out_ready && !clear;

    assign w_swapped = {right_block, left_block};

`ifdef ROUND_COMBINER_FP_EN
    // IP^-1 as a pure wire remap; source bit index follows the DES FP table
    // (1-based, bit 1 = MSB), whose columns alternate between the 40.. and 8..
    // sequences and step down by one per row.
    for (genvar gi = 0; gi < 64; gi++) begin : g_fp
        localparam int c_ROW = gi / 8;
        localparam int c_COL = gi % 8;
        localparam int c_SRC = (((c_COL % 2) == 0) ? 40 : 8) - c_ROW + 8 * (c_COL / 2);
        assign w_push_data[63-gi] = w_swapped[64-c_SRC];
    end
`else
    assign w_push_data = w_swapped;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_round_count <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_hold        <= '0;
            r_block_done  <= 1'b0;
        end else if (clear) begin
            r_round_count <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_hold        <= '0;
            r_block_done  <= 1'b0;
        end else begin
            r_block_done <= w_push;
            if (w_accept) begin
                r_round_count <= w_last ? 6'd0 : r_round_count + 6'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // When drained, the last popped head is held instead of a stale slot.
    assign data_out    = w_empty ? r_hold : r_mem[r_rd_ptr];
    assign data_valid  = !w_empty;
    assign round_count = r_round_count;
    assign block_done  = r_block_done;

endmodule

`default_nettype wire

// File: tb/tb_round_combiner.sv
// ============================================================================
//  Module   : tb_round_combiner
//  Purpose  : Directed, table-driven self-checking bench for round_combiner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_combiner;

    logic        clk;
    logic        n_rst;
    logic        clear;
    logic [31:0] left_block;
    logic [31:0] right_block;
    logic        round_valid;
    logic        in_ready;
    logic [63:0] data_out;
    logic        data_valid;
    logic        out_ready;
    logic [5:0]  round_count;
    logic        block_done;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [63:0] raw;
    } vec_t;

    vec_t vt [5];

    round_combiner #(
        .NUM_ROUNDS (16),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .left_block  (left_block),
        .right_block (right_block),
        .round_valid (round_valid),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .out_ready   (out_ready),
        .round_count (round_count),
        .block_done  (block_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (block_done) n_done++;
    end

`ifdef ROUND_COMBINER_FP_EN
    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };
`endif

    function automatic logic [63:0] exp_of(input logic [63:0] raw);
`ifdef ROUND_COMBINER_FP_EN
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = raw[64-FP_TAB[i]];
        return o;
`else
        return raw;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_round(input logic [31:0] l, input logic [31:0] r);
        round_valid = 1'b1;
        left_block  = l;
        right_block = r;
        tick();
        round_valid = 1'b0;
    endtask

    task automatic do_rounds(input int n);
        for (int k = 0; k < n; k++) do_round(32'h1000_0000 + k, 32'h2000_0000 + k);
    endtask

    task automatic push_block(input int idx);
        do_rounds(15);
        do_round(vt[idx].l, vt[idx].r);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{32'h01234567, 32'h89ABCDEF, 64'h89ABCDEF_01234567};
        vt[1] = '{32'hDEADBEEF, 32'hCAFEF00D, 64'hCAFEF00D_DEADBEEF};
        vt[2] = '{32'h00000000, 32'h00000001, 64'h00000001_00000000};
        vt[3] = '{32'hFFFFFFFF, 32'h00000000, 64'h00000000_FFFFFFFF};
        vt[4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 64'h5A5A5A5A_A5A5A5A5};

        n_rst = 1'b0; clear = 1'b0; round_valid = 1'b0; out_ready = 1'b0;
        left_block = '0; right_block = '0;

        #12;
        chk("rst_round_count", 64'(round_count), 64'd0);
        chk("rst_data_valid",  64'(data_valid),  64'd0);
        chk("rst_data_out",    data_out,         64'd0);
        chk("rst_block_done",  64'(block_done),  64'd0);
        n_rst = 1'b1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // First block: latency, swap, single block_done pulse
        do_rounds(15);
        chk("b0_count15", 64'(round_count), 64'd15);
        do_round(vt[0].l, vt[0].r);
        chk("b0_valid",      64'(data_valid),  64'd1);
        chk("b0_data",       data_out,         exp_of(vt[0].raw));
        chk("b0_done",       64'(block_done),  64'd1);
        chk("b0_count_wrap", 64'(round_count), 64'd0);
        tick();
        chk("b0_done_pulse", 64'(block_done), 64'd0);
        chk("b0_still_valid", 64'(data_valid), 64'd1);
        pop_one();
        chk("b0_empty", 64'(data_valid), 64'd0);
        chk("b0_hold",  data_out,        exp_of(vt[0].raw));

        // Table sweep: push, compare head, drain
        for (int i = 1; i < 5; i++) begin
            push_block(i);
            chk($sformatf("vec%0d_data", i),  data_out,        exp_of(vt[i].raw));
            chk($sformatf("vec%0d_done", i),  64'(block_done), 64'd1);
            pop_one();
            chk($sformatf("vec%0d_empty", i), 64'(data_valid), 64'd0);
        end

        // Backpressure: FIFO full stalls the 16th round only
        push_block(1);
        push_block(2);
        do_rounds(15);
        chk("bp_count15", 64'(round_count), 64'd15);
        chk("bp_stall",   64'(in_ready),    64'd0);
        do_round(vt[4].l, vt[4].r);
        chk("bp_ignored_count", 64'(round_count), 64'd15);
        chk("bp_ignored_done",  64'(block_done),  64'd0);
        chk("bp_head1",         data_out,         exp_of(vt[1].raw));
        pop_one();
        chk("bp_ready_again", 64'(in_ready), 64'd1);
        chk("bp_head2",       data_out,      exp_of(vt[2].raw));
        do_round(vt[3].l, vt[3].r);
        chk("bp_third_done", 64'(block_done), 64'd1);
        chk("bp_order2",     data_out,        exp_of(vt[2].raw));
        pop_one();
        chk("bp_order3", data_out, exp_of(vt[3].raw));
        pop_one();
        chk("bp_drained", 64'(data_valid), 64'd0);

        // Simultaneous push and pop with one entry held
        push_block(0);
        do_rounds(15);
        out_ready = 1'b1;
        do_round(vt[4].l, vt[4].r);
        out_ready = 1'b0;
        chk("pp_valid", 64'(data_valid), 64'd1);
        chk("pp_data",  data_out,        exp_of(vt[4].raw));
        chk("pp_done",  64'(block_done), 64'd1);
        pop_one();
        chk("pp_occ_one", 64'(data_valid), 64'd0);

        // Clear beats a concurrent round and flushes the FIFO
        push_block(1);
        do_rounds(7);
        chk("clr_count7", 64'(round_count), 64'd7);
        clear = 1'b1;
        out_ready = 1'b1;
        do_round(32'h0BAD_0BAD, 32'h0BAD_0BAD);
        clear = 1'b0;
        out_ready = 1'b0;
        chk("clr_count", 64'(round_count), 64'd0);
        chk("clr_valid", 64'(data_valid),  64'd0);
        chk("clr_data",  data_out,         64'd0);
        chk("clr_done",  64'(block_done),  64'd0);

        // Asynchronous reset mid-block, then one clean block
        push_block(2);
        do_rounds(10);
        chk("ar_count10", 64'(round_count), 64'd10);
        chk("ar_valid",   64'(data_valid),  64'd1);
        #3 n_rst = 1'b0;
        #1;
        chk("ar_count", 64'(round_count), 64'd0);
        chk("ar_dv",    64'(data_valid),  64'd0);
        chk("ar_data",  data_out,         64'd0);
        chk("ar_done",  64'(block_done),  64'd0);
        #2 n_rst = 1'b1;
        n_done = 0;
        push_block(3);
        chk("ar_new_data", data_out, exp_of(vt[3].raw));
        tick();
        tick();
        chk("ar_one_block", 64'(n_done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
